// File: rtl/i2c_eeprom_slave.sv
// I2C slave with a byte-addressed internal memory (two address bytes, sequential read/write).
// Optional write protect input is added when I2C_SLV_WR_PROTECT_EN is defined.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter int         MEM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
`ifdef I2C_SLV_WR_PROTECT_EN
  input  logic              wp,
`endif
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_done,
  output logic [MEM_AW-1:0] cur_addr
);

  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDRH, ADDRH_ACK, ADDRL, ADDRL_ACK,
    WR_DAT, WR_ACK, RD_DAT, RD_ACK
  } state_t;

  state_t state_reg, state_next;

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0] meta_reg, sync_reg, prev_reg;

  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        tx_reg, tx_next;
  logic              mack_reg, mack_next;
  logic              sda_oe_reg, sda_oe_next;
  logic              busy_reg, busy_next;
  logic              wr_done_reg, wr_done_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  logic [MEM_AW-1:0] addr_load;
  logic              mem_we;
  logic              wr_en;
  logic [7:0]        rd_data_reg;
  logic [7:0]        mem [0:(1<<MEM_AW)-1];

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic rx_bit, byte_done;
  logic [2:0] tx_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
      prev_reg <= 2'b11;
    end else begin
      meta_reg <= {sda_i, scl_i};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign scl_s     = sync_reg[0];
  assign scl_p     = prev_reg[0];
  assign sda_s     = sync_reg[1];
  assign sda_p     = prev_reg[1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  // A data bit arrives on each of the first eight rises; the byte is acted on at the 8th fall.
  assign rx_bit    = scl_rise && (bit_cnt_reg != 4'd8);
  assign byte_done = scl_fall && (bit_cnt_reg == 4'd8);
  assign tx_idx    = 3'd7 - bit_cnt_reg[2:0];

`ifdef I2C_SLV_WR_PROTECT_EN
  assign wr_en = ~wp;
`else
  assign wr_en = 1'b1;
`endif

  // The high address byte only matters when the memory is deeper than 256 bytes.
  generate
    if (MEM_AW > 8) begin : g_addr_hi
      logic [MEM_AW-9:0] addrh_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          addrh_reg <= '0;
        end else if (state_reg == ADDRH && byte_done) begin
          addrh_reg <= shift_reg[MEM_AW-9:0];
        end
      end
      assign addr_load = {addrh_reg, shift_reg};
    end else begin : g_addr_lo
      assign addr_load = shift_reg[MEM_AW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'd0;
      tx_reg      <= 8'd0;
      mack_reg    <= 1'b0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      wr_done_reg <= 1'b0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      mack_reg    <= mack_next;
      sda_oe_reg  <= sda_oe_next;
      busy_reg    <= busy_next;
      wr_done_reg <= wr_done_next;
      addr_reg    <= addr_next;
    end
  end

  // Contents survive reset; read port is registered and tracks the pointer every cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_reg] <= shift_reg;
    end
    rd_data_reg <= mem[addr_reg];
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    mack_next    = mack_reg;
    sda_oe_next  = sda_oe_reg;
    busy_next    = busy_reg;
    wr_done_next = 1'b0;
    addr_next    = addr_reg;
    mem_we       = 1'b0;

    if (stop_det) begin
      state_next   = IDLE;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      bit_cnt_next = 4'd0;
    end else if (start_det) begin
      state_next   = DEV;
      sda_oe_next  = 1'b0;
      bit_cnt_next = 4'd0;
    end else begin
      case (state_reg)
        DEV, ADDRH, ADDRL, WR_DAT: begin
          if (rx_bit) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (byte_done) begin
            bit_cnt_next = 4'd0;
            case (state_reg)
              DEV: begin
                if (shift_reg[7:1] == DEV_ADDR) begin
                  state_next  = DEV_ACK;
                  sda_oe_next = 1'b1;
                  busy_next   = 1'b1;
                end else begin
                  state_next  = IDLE;
                  sda_oe_next = 1'b0;
                end
              end
              ADDRH: begin
                state_next  = ADDRH_ACK;
                sda_oe_next = 1'b1;
              end
              ADDRL: begin
                state_next  = ADDRL_ACK;
                sda_oe_next = 1'b1;
              end
              default: begin
                state_next   = WR_ACK;
                addr_next    = addr_reg + ADDR_ONE;
                sda_oe_next  = wr_en;
                mem_we       = wr_en;
                wr_done_next = wr_en;
              end
            endcase
          end
        end

        DEV_ACK: begin
          if (scl_fall) begin
            if (shift_reg[0]) begin
              state_next  = RD_DAT;
              tx_next     = rd_data_reg;
              sda_oe_next = ~rd_data_reg[7];
            end else begin
              state_next  = ADDRH;
              sda_oe_next = 1'b0;
            end
          end
        end

        ADDRH_ACK: begin
          if (scl_fall) begin
            state_next  = ADDRL;
            sda_oe_next = 1'b0;
          end
        end

        ADDRL_ACK: begin
          if (scl_fall) begin
            state_next  = WR_DAT;
            sda_oe_next = 1'b0;
            addr_next   = addr_load;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            state_next  = WR_DAT;
            sda_oe_next = 1'b0;
          end
        end

        RD_DAT: begin
          if (rx_bit) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (byte_done) begin
            state_next   = RD_ACK;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            mack_next    = 1'b0;
            addr_next    = addr_reg + ADDR_ONE;
          end else if (scl_fall && bit_cnt_reg != 4'd0) begin
            sda_oe_next = ~tx_reg[tx_idx];
          end
        end

        RD_ACK: begin
          // Master ACK is remembered at the 9th rise; the next byte starts on the 9th fall.
          if (scl_rise) begin
            if (sda_s) begin
              state_next = IDLE;
            end else begin
              mack_next = 1'b1;
            end
          end else if (scl_fall && mack_reg) begin
            state_next  = RD_DAT;
            mack_next   = 1'b0;
            tx_next     = rd_data_reg;
            sda_oe_next = ~rd_data_reg[7];
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign busy     = busy_reg;
  assign wr_done  = wr_done_reg;
  assign cur_addr = addr_reg;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged master plus a byte-level model of the slave's
// expected ACKs, read data, pointer and busy flag, compared every cycle while SCL is high.
module tb_i2c_eeprom_slave;

  localparam int Q = 8;  // quarter bit period in clk cycles

  localparam int M_IDLE = 0, M_DEV = 1, M_AH = 2, M_AL = 3, M_WD = 4, M_RD = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic sda_oe, busy, wr_done;
  logic [7:0] cur_addr;
  logic wp_val = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave #(.DEV_ADDR(7'b1010000), .MEM_AW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
`ifdef I2C_SLV_WR_PROTECT_EN
    .wp      (wp_val),
`endif
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_done (wr_done),
    .cur_addr(cur_addr)
  );

  int vectors = 0;
  int miscompares = 0;
  int dut_wr_count = 0;
  int txn = 0;

  // expectations shown to the compare process
  logic       chk = 1'b0;
  logic       exp_oe = 1'b0;
  logic       exp_oe_known = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_addr = 8'h00;

  // byte-level model of the slave
  logic [7:0] m_mem [256];
  bit         m_valid [256];
  logic [7:0] m_ptr = 8'h00;
  logic       m_busy = 1'b0;
  int         m_mode = M_IDLE;
  int         m_wr_count = 0;

  function automatic logic model_wp();
`ifdef I2C_SLV_WR_PROTECT_EN
    return wp_val;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; outputs are compared only in the settled middle of the high phase.
  task automatic bit_cycle(input logic drive, input logic oe_e, input logic oe_k, output logic smp);
    sda_m = drive;
    wait_clk(Q);
    exp_oe = oe_e;
    exp_oe_known = oe_k;
    exp_busy = m_busy;
    exp_addr = m_ptr;
    scl_m = 1'b1;
    wait_clk(5);
    chk = 1'b1;
    wait_clk(2 * Q - 10);
    smp = sda_line;
    chk = 1'b0;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
    m_mode = M_DEV;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
    m_mode = M_IDLE;
    m_busy = 1'b0;
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("oe_after_stop", {31'd0, sda_oe}, 32'd0);
    check("wr_done_count", dut_wr_count, m_wr_count);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    logic exp_ack;
    case (m_mode)
      M_DEV:      exp_ack = (b[7:1] == 7'h50);
      M_AH, M_AL: exp_ack = 1'b1;
      M_WD:       exp_ack = ~model_wp();
      default:    exp_ack = 1'b0;
    endcase
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, 1'b1, s);
    if (m_mode == M_DEV && exp_ack) m_busy = 1'b1;
    if (m_mode == M_WD) begin
      if (!model_wp()) begin
        m_mem[m_ptr] = b;
        m_valid[m_ptr] = 1'b1;
        m_wr_count++;
      end
      m_ptr = m_ptr + 8'd1;
    end
    bit_cycle(1'b1, exp_ack, 1'b1, s);
    ack = ~s;
    case (m_mode)
      M_DEV: m_mode = exp_ack ? (b[0] ? M_RD : M_AH) : M_IDLE;
      M_AH:  m_mode = M_AL;
      M_AL: begin
        m_ptr = b;  // only the low byte matters for a 256-byte memory
        m_mode = M_WD;
      end
      default: ;
    endcase
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    logic [7:0] want;
    logic known;
    want = m_mem[m_ptr];
    known = m_valid[m_ptr];
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, ~want[i], known, s);
      d[i] = s;
    end
    m_ptr = m_ptr + 8'd1;
    bit_cycle(nack, 1'b0, 1'b1, s);
    if (nack) m_mode = M_IDLE;
  endtask

  task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo);
    logic a;
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(hi, a);
    send_byte(lo, a);
  endtask

  task automatic do_write(input logic [7:0] lo, input int n);
    logic a;
    logic [7:0] d;
    addr_phase(8'($urandom_range(0, 255)), lo);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      send_byte(d, a);
    end
    i2c_stop();
    $display("txn %0d: write addr=%02h n=%0d wp=%0b ptr=%02h", txn, lo, n, model_wp(), cur_addr);
  endtask

  task automatic do_read(input logic [7:0] lo, input int n, input bit set_addr);
    logic a;
    logic [7:0] d;
    if (set_addr) addr_phase(8'h00, lo);
    i2c_start();
    send_byte(8'hA1, a);
    for (int i = 0; i < n; i++) read_byte(i == n - 1, d);
    i2c_stop();
    $display("txn %0d: read set_addr=%0b addr=%02h n=%0d last=%02h", txn, set_addr, lo, n, d);
  endtask

  function automatic logic [7:0] pick_addr();
    return 8'($urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? 8'hF8 : 8'h10);
  endfunction

  // compare process
  initial begin
    logic wr_prev;
    wr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (chk) begin
        vectors++;
        if (exp_oe_known && sda_oe !== exp_oe) begin
          miscompares++;
          $display("FAIL sda_oe @%0t: got %b, required %b", $time, sda_oe, exp_oe);
        end
        if (busy !== exp_busy) begin
          miscompares++;
          $display("FAIL busy @%0t: got %b, required %b", $time, busy, exp_busy);
        end
        if (cur_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL cur_addr @%0t: got %02h, required %02h", $time, cur_addr, exp_addr);
        end
      end
      if (wr_done === 1'b1) dut_wr_count++;
      if (wr_done === 1'b1 && wr_prev) begin
        miscompares++;
        $display("FAIL wr_done_width @%0t: got 2+ cycles, required 1", $time);
      end
      wr_prev = (wr_done === 1'b1);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    logic [7:0] d0, d1;
    int op;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 8'h00;
      m_valid[i] = 1'b0;
    end

    // reset state
    wait_clk(6);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check("rst_cur_addr", {24'd0, cur_addr}, 32'h00);
    rst = 1'b0;
    wait_clk(4);

    // single byte write
    txn++;
    i2c_start();
    send_byte(8'hA0, a);  check("w1_dev_ack", {31'd0, a}, 32'd1);
    send_byte(8'h00, a);  check("w1_ah_ack", {31'd0, a}, 32'd1);
    send_byte(8'h12, a);  check("w1_al_ack", {31'd0, a}, 32'd1);
    send_byte(8'hA5, a);  check("w1_data_ack", {31'd0, a}, 32'd1);
    i2c_stop();
    check("w1_cur_addr", {24'd0, cur_addr}, 32'h13);
    check("w1_wr_pulses", dut_wr_count, 32'd1);
    check("w1_model_mem", {24'd0, m_mem[8'h12]}, 32'hA5);
    $display("txn %0d: write 12<=A5 ptr=%02h", txn, cur_addr);

    // random read via repeated START
    txn++;
    do_read(8'h12, 1, 1'b1);
    check("r1_busy", {31'd0, busy}, 32'd0);
    txn++;
    addr_phase(8'h00, 8'h12);
    i2c_start();
    send_byte(8'hA1, a);
    read_byte(1'b1, d0);
    i2c_stop();
    check("r1_data", {24'd0, d0}, 32'hA5);
    $display("txn %0d: read 12 -> %02h", txn, d0);

    // foreign device address
    txn++;
    i2c_start();
    send_byte(8'hB0, a);
    check("nomatch_ack", {31'd0, a}, 32'd0);
    check("nomatch_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    $display("txn %0d: address B0 ack=%0b", txn, a);

    // pointer wrap on write and read
    txn++;
    addr_phase(8'h00, 8'hFF);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    i2c_stop();
    check("wrap_w_addr", {24'd0, cur_addr}, 32'h01);
    check("wrap_w_pulses", dut_wr_count, 32'd3);
    txn++;
    addr_phase(8'h00, 8'hFF);
    i2c_start();
    send_byte(8'hA1, a);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    check("wrap_r_d0", {24'd0, d0}, 32'h11);
    check("wrap_r_d1", {24'd0, d1}, 32'h22);
    check("wrap_r_addr", {24'd0, cur_addr}, 32'h01);
    $display("txn %0d: wrap read FF -> %02h %02h", txn, d0, d1);

    // STOP part way through a data byte
    txn++;
    addr_phase(8'h00, 8'h40);
    send_byte(8'h3C, a);
    i2c_stop();
    txn++;
    addr_phase(8'h00, 8'h40);
    for (int i = 7; i >= 4; i--) bit_cycle(i[0], 1'b0, 1'b1, a);
    i2c_stop();
    check("partial_addr", {24'd0, cur_addr}, 32'h40);
    check("partial_pulses", dut_wr_count, 32'd4);
    do_read(8'h40, 1, 1'b1);
    check("partial_mem_model", {24'd0, m_mem[8'h40]}, 32'h3C);

`ifdef I2C_SLV_WR_PROTECT_EN
    // write protect
    txn++;
    addr_phase(8'h00, 8'h20);
    send_byte(8'h77, a);
    i2c_stop();
    wp_val = 1'b1;
    txn++;
    addr_phase(8'h00, 8'h20);
    send_byte(8'h5A, a);
    check("wp_data_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    check("wp_cur_addr", {24'd0, cur_addr}, 32'h21);
    check("wp_pulses", dut_wr_count, 32'd5);
    wp_val = 1'b0;
    txn++;
    addr_phase(8'h00, 8'h20);
    i2c_start();
    send_byte(8'hA1, a);
    read_byte(1'b1, d0);
    i2c_stop();
    check("wp_mem", {24'd0, d0}, 32'h77);
    $display("txn %0d: write protect read 20 -> %02h", txn, d0);
`endif

    // reset while the slave is driving read data
    txn++;
    addr_phase(8'h00, 8'h30);
    send_byte(8'h15, a);
    i2c_stop();
    txn++;
    addr_phase(8'h00, 8'h30);
    i2c_start();
    send_byte(8'hA1, a);
    check("pre_reset_oe", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_addr", {24'd0, cur_addr}, 32'h00);
    rst = 1'b0;
    m_ptr = 8'h00;
    m_busy = 1'b0;
    m_mode = M_IDLE;
    wait_clk(4);
    i2c_stop();
    $display("txn %0d: reset during read", txn);
    txn++;
    addr_phase(8'h00, 8'h30);
    i2c_start();
    send_byte(8'hA1, a);
    read_byte(1'b1, d0);
    i2c_stop();
    check("mem_persist", {24'd0, d0}, 32'h15);
    $display("txn %0d: read after reset 30 -> %02h", txn, d0);

    // randomized traffic
    for (int t = 0; t < 16; t++) begin
      txn++;
`ifdef I2C_SLV_WR_PROTECT_EN
      wp_val = ($urandom_range(0, 3) == 0);
`endif
      op = $urandom_range(0, 4);
      case (op)
        0: do_write(pick_addr(), $urandom_range(1, 3));
        1: do_read(pick_addr(), $urandom_range(1, 3), 1'b1);
        2: do_read(8'h00, $urandom_range(1, 2), 1'b0);
        3: begin
          logic [7:0] dv;
          dv = 8'($urandom_range(0, 255));
          while (dv[7:1] == 7'h50) dv = 8'($urandom_range(0, 255));
          i2c_start();
          send_byte(dv, a);
          i2c_stop();
          $display("txn %0d: foreign address %02h ack=%0b", txn, dv, a);
        end
        default: begin
          int k;
          k = $urandom_range(1, 7);
          addr_phase(8'h00, pick_addr());
          for (int i = 0; i < k; i++) bit_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, a);
          i2c_stop();
          $display("txn %0d: partial byte %0d bits ptr=%02h", txn, k, cur_addr);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1010000: 7-bit device address the block responds to.
REQ-002 SHALL have parameter MEM_AW, default 8: internal memory address width, giving 2**MEM_AW bytes.
REQ-003 SHALL have port clk, input, 1 bit: system clock, 50 MHz nominal; the only clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port scl_i, input, 1 bit: raw bus SCL, asynchronous to clk.
REQ-006 SHALL have port sda_i, input, 1 bit: raw bus SDA, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases SDA (open-drain).
REQ-008 SHALL have port busy, output, 1 bit: high from an addressed START until the next STOP.
REQ-009 SHALL have port wr_done, output, 1 bit: one-clk pulse per byte stored to memory.
REQ-010 SHALL have port cur_addr, output, MEM_AW bits: current memory address pointer.

Function
REQ-011 SHALL pass scl_i and sda_i through 2-flop synchronizers, then detect SCL rise/fall from registered samples.
REQ-012 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high (synchronized signals).
REQ-013 SHALL treat START in any state, repeated START included, as entry to DEV with bit counter cleared; SHALL treat STOP in any state as entry to IDLE with sda_oe=0.
REQ-014 SHALL sample data bits on SCL rise, MSB first, and change sda_oe only on SCL fall.
REQ-015 SHALL implement these states: IDLE, DEV, DEV_ACK, ADDRH, ADDRH_ACK, ADDRL, ADDRL_ACK, WR_DAT, WR_ACK, RD_DAT, RD_ACK.
REQ-016 DEV: after 8 bits, on an address match go to DEV_ACK and drive ACK (sda_oe=1) from the 8th SCL fall to the 9th SCL fall; on a mismatch release SDA and go to IDLE until the next START.
REQ-017 Match with R/W=0 SHALL lead to ADDRH; match with R/W=1 SHALL lead to RD_DAT.
REQ-018 ADDRH/ADDRL SHALL each be ACKed; the pointer SHALL be loaded from {ADDRH,ADDRL}[MEM_AW-1:0] after the ADDRL ACK, with higher bits ignored; then go to WR_DAT.
REQ-019 WR_DAT: after 8 bits write the byte to mem[cur_addr], pulse wr_done, ACK (WR_ACK), increment cur_addr, and return to WR_DAT.
REQ-020 RD_DAT: load mem[cur_addr] on entry; for each bit, on SCL fall set sda_oe = ~bit. After 8 bits, release SDA, increment cur_addr, and sample the master ACK on the 9th SCL rise: ACK (0) leads to RD_DAT with the next byte; NACK (1) leads to IDLE.
REQ-021 cur_addr SHALL wrap from 2**MEM_AW-1 to 0 on both read and write.
REQ-022 A STOP or START before the 8th bit of a WR_DAT byte SHALL discard the partial byte, with no memory write and no wr_done.
REQ-023 busy SHALL assert on entry to DEV_ACK on a match and deassert on STOP.
REQ-024 The memory pointer and contents SHALL persist across transactions, so that a write-address phase, repeated START, and read give a random read.

Reset
REQ-025 While rst=1: state=IDLE, sda_oe=0, busy=0, wr_done=0, cur_addr=0, synchronizers=1.
REQ-026 Reset SHALL NOT clear memory contents; reset mid-transfer SHALL abort immediately with SDA released.

Configuration
REQ-027 Macro I2C_SLV_WR_PROTECT_EN, when defined, SHALL add input wp (1 bit) after sda_i.
REQ-028 With the macro defined and wp=1, WR_DAT bytes SHALL NOT be written, wr_done SHALL stay 0, data bytes SHALL be NACKed (sda_oe=0), and cur_addr SHALL still increment; address bytes SHALL still be ACKed.
REQ-029 With the macro undefined, there SHALL be no wp port and writes are always enabled.

Verification
REQ-030 Write 0xA0, 0x00, 0x12, 0xA5, STOP -> three ACKs plus one data ACK, mem[0x12]=0xA5, one wr_done pulse, cur_addr=0x13.
REQ-031 Write 0xA0, 0x00, 0x12, repeated START, 0xA1, read 1 byte, master NACK -> SDA returns 0xA5, then IDLE, busy=0 after STOP.
REQ-032 Address 0xB0 -> no ACK on the 9th clock, sda_oe stays 0 for the whole frame, busy=0.
REQ-033 Pointer 0xFF, write 0x11 then 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; sequential read from 0xFF returns 0x11, 0x22.
REQ-034 STOP after 4 bits of a data byte -> no memory change, no wr_done, state IDLE, sda_oe=0.
REQ-035 With I2C_SLV_WR_PROTECT_EN defined and wp=1, write 0x5A to 0x20 -> data byte NACKed, mem[0x20] unchanged, cur_addr=0x21.
